// File: rtl/sprite_motion_pkg.sv
// Shared types for the sprite motion controller: FSM states, axis directions and
// the per-axis reflect/step helper used by both the X and Y update states.
package sprite_motion_pkg;

  localparam int CALC_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_NF,
    ST_UPD_X,
    ST_UPD_Y,
    ST_COMMIT
  } state_e;

  // Encoded so that an LFSR bit of 1 maps straight onto the positive direction.
  typedef enum logic {
    DIR_NEG = 1'b0,
    DIR_POS = 1'b1
  } dir_e;

  typedef struct packed {
    logic [CALC_W-1:0] pos;
    dir_e              dir;
    logic              bounce;
  } axis_t;

  // One frame of motion on a single axis, clamping and reflecting at 0 and limit.
  function automatic axis_t step_axis(input logic [CALC_W-1:0] pos,
                                      input dir_e              dir,
                                      input logic [CALC_W-1:0] speed,
                                      input logic [CALC_W-1:0] limit);
    axis_t r;
    r.pos    = pos;
    r.dir    = dir;
    r.bounce = 1'b0;
    if (dir == DIR_POS) begin
      if (pos + speed >= limit) begin
        r.pos    = limit;
        r.dir    = DIR_NEG;
        r.bounce = 1'b1;
      end else begin
        r.pos = pos + speed;
      end
    end else begin
      if (pos <= speed) begin
        r.pos    = '0;
        r.dir    = DIR_POS;
        r.bounce = 1'b1;
      end else begin
        r.pos = pos - speed;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11, synchronous reset to SEED.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_en,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else if (step_en) begin
      state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
    end
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Bouncing-sprite position controller, one position update per accepted frame.
// Define SPRITE_MOTION_LFSR_EN to randomise launch directions from an LFSR.
module sprite_motion_ctrl
  import sprite_motion_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int SPRITE_W = 20,
  parameter int SPRITE_H = 24,
  parameter int SPEED    = 4
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic        nf_in,
  input  logic        launch_in,
  input  logic        freeze_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        moving_out,
  output logic        upd_valid_out,
  output logic        bounce_out
);

  localparam logic [CALC_W-1:0] X_LIM = CALC_W'(H_ACTIVE - SPRITE_W);
  localparam logic [CALC_W-1:0] Y_LIM = CALC_W'(V_ACTIVE - SPRITE_H);
  localparam logic [CALC_W-1:0] SPD   = CALC_W'(SPEED);

  state_e            state;
  logic              launch_q;
  logic              launch_rise;
  logic [CALC_W-1:0] x_calc;
  logic [CALC_W-1:0] y_calc;
  dir_e              dir_x;
  dir_e              dir_y;
  logic              bnc_x;
  logic              bnc_y;
  dir_e              launch_dir_x;
  dir_e              launch_dir_y;
  axis_t             nx;
  axis_t             ny;

`ifdef SPRITE_MOTION_LFSR_EN
  logic [15:0] lfsr_state;

  lfsr16 u_lfsr (
    .clk     (pixel_clk_in),
    .rst     (rst_in),
    .step_en (1'b1),
    .state   (lfsr_state)
  );

  assign launch_dir_x = dir_e'(lfsr_state[0]);
  assign launch_dir_y = dir_e'(lfsr_state[1]);
`else
  assign launch_dir_x = DIR_POS;
  assign launch_dir_y = DIR_POS;
`endif

  assign launch_rise = launch_in & ~launch_q;

  // x_calc/y_calc always hold the last committed position between frames,
  // so they serve as both the working register and the step source.
  assign nx = step_axis(x_calc, dir_x, SPD, X_LIM);
  assign ny = step_axis(y_calc, dir_y, SPD, Y_LIM);

  // NOTE: every register here is updated with <= so all reads in this block see
  // the pre-edge value; a blocking = would leak same-cycle values into later lines.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state         <= ST_IDLE;
      // Tracking the level during reset keeps a held-high launch from looking like an edge.
      launch_q      <= launch_in;
      x_calc        <= '0;
      y_calc        <= '0;
      dir_x         <= DIR_POS;
      dir_y         <= DIR_POS;
      bnc_x         <= 1'b0;
      bnc_y         <= 1'b0;
      x_out         <= '0;
      y_out         <= '0;
      moving_out    <= 1'b0;
      upd_valid_out <= 1'b0;
      bounce_out    <= 1'b0;
    end else begin
      launch_q      <= launch_in;
      upd_valid_out <= 1'b0;
      bounce_out    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (launch_rise) begin
            state      <= ST_WAIT_NF;
            dir_x      <= launch_dir_x;
            dir_y      <= launch_dir_y;
            moving_out <= 1'b1;
          end
        end
        ST_WAIT_NF: begin
          if (launch_rise) begin
            state      <= ST_IDLE;
            moving_out <= 1'b0;
          end else if (nf_in && !freeze_in) begin
            state <= ST_UPD_X;
          end
        end
        ST_UPD_X: begin
          x_calc <= nx.pos;
          dir_x  <= nx.dir;
          bnc_x  <= nx.bounce;
          state  <= ST_UPD_Y;
        end
        ST_UPD_Y: begin
          y_calc <= ny.pos;
          dir_y  <= ny.dir;
          bnc_y  <= ny.bounce;
          state  <= ST_COMMIT;
        end
        ST_COMMIT: begin
          x_out         <= x_calc[10:0];
          y_out         <= y_calc[9:0];
          upd_valid_out <= 1'b1;
          bounce_out    <= bnc_x | bnc_y;
          state         <= ST_WAIT_NF;
        end
        default: begin
          state      <= ST_IDLE;
          moving_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench: default-size instance plus a small-field instance that hits
// a lone Y reflection and a simultaneous X/Y reflection within a few frames.
module tb_sprite_motion_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        nf = 1'b0;
  logic        launch = 1'b0;
  logic        freeze = 1'b0;

  logic [10:0] bx;
  logic [9:0]  by;
  logic        bmov, bupd, bbnc;
  logic [10:0] sx;
  logic [9:0]  sy;
  logic        smov, supd, sbnc;

  int n_checks = 0;
  int n_fail   = 0;

  // Values captured at the commit cycle of the most recent frame.
  logic [10:0] cap_bx, cap_sx;
  logic [9:0]  cap_by, cap_sy;
  logic        cap_bupd, cap_bbnc, cap_supd, cap_sbnc;
  int          upd_cnt;

  always #5 clk = ~clk;

  sprite_motion_ctrl dut (
    .pixel_clk_in  (clk),
    .rst_in        (rst),
    .nf_in         (nf),
    .launch_in     (launch),
    .freeze_in     (freeze),
    .x_out         (bx),
    .y_out         (by),
    .moving_out    (bmov),
    .upd_valid_out (bupd),
    .bounce_out    (bbnc)
  );

  // X limit 42 and Y limit 20 with step 3: Y reflects at frame 7,
  // then both axes reflect together at frame 14 (Y arriving from 2).
  sprite_motion_ctrl #(
    .H_ACTIVE (58),
    .V_ACTIVE (36),
    .SPRITE_W (16),
    .SPRITE_H (16),
    .SPEED    (3)
  ) dut_s (
    .pixel_clk_in  (clk),
    .rst_in        (rst),
    .nf_in         (nf),
    .launch_in     (launch),
    .freeze_in     (freeze),
    .x_out         (sx),
    .y_out         (sy),
    .moving_out    (smov),
    .upd_valid_out (supd),
    .bounce_out    (sbnc)
  );

  typedef struct {
    int          frame;
    logic [10:0] bx;
    logic [9:0]  by;
    logic        bb;
    logic        chk_s;
    logic [10:0] sx;
    logic [9:0]  sy;
    logic        sb;
  } vec_t;

  vec_t tbl[15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One nf pulse, then four more edges; captures outputs after edge E+3.
  task automatic do_frame();
    upd_cnt = 0;
    nf = 1'b1;
    tick();
    nf = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (bupd) upd_cnt++;
      if (c == 3) begin
        cap_bx = bx; cap_by = by; cap_bupd = bupd; cap_bbnc = bbnc;
        cap_sx = sx; cap_sy = sy; cap_supd = supd; cap_sbnc = sbnc;
      end
    end
  endtask

  task automatic launch_pulse();
    launch = 1'b0;
    tick();
    launch = 1'b1;
    tick();
    launch = 1'b0;
  endtask

  initial begin
    int idx;

    tbl[0]  = '{2,   11'd8,    10'd8,   1'b0, 1'b1, 11'd6,  10'd6,  1'b0};
    tbl[1]  = '{6,   11'd24,   10'd24,  1'b0, 1'b1, 11'd18, 10'd18, 1'b0};
    tbl[2]  = '{7,   11'd28,   10'd28,  1'b0, 1'b1, 11'd21, 10'd20, 1'b1};
    tbl[3]  = '{8,   11'd32,   10'd32,  1'b0, 1'b1, 11'd24, 10'd17, 1'b0};
    tbl[4]  = '{13,  11'd52,   10'd52,  1'b0, 1'b1, 11'd39, 10'd2,  1'b0};
    tbl[5]  = '{14,  11'd56,   10'd56,  1'b0, 1'b1, 11'd42, 10'd0,  1'b1};
    tbl[6]  = '{15,  11'd60,   10'd60,  1'b0, 1'b1, 11'd39, 10'd3,  1'b0};
    tbl[7]  = '{174, 11'd696,  10'd696, 1'b1, 1'b0, 11'd0,  10'd0,  1'b0};
    tbl[8]  = '{175, 11'd700,  10'd692, 1'b0, 1'b0, 11'd0,  10'd0,  1'b0};
    tbl[9]  = '{313, 11'd1252, 10'd140, 1'b0, 1'b0, 11'd0,  10'd0,  1'b0};
    tbl[10] = '{314, 11'd1256, 10'd136, 1'b0, 1'b0, 11'd0,  10'd0,  1'b0};
    tbl[11] = '{315, 11'd1260, 10'd132, 1'b1, 1'b0, 11'd0,  10'd0,  1'b0};
    tbl[12] = '{316, 11'd1256, 10'd128, 1'b0, 1'b0, 11'd0,  10'd0,  1'b0};
    tbl[13] = '{317, 11'd1252, 10'd124, 1'b0, 1'b0, 11'd0,  10'd0,  1'b0};
    tbl[14] = '{318, 11'd1248, 10'd120, 1'b0, 1'b0, 11'd0,  10'd0,  1'b0};

    // Reset with launch held high across deassertion.
    launch = 1'b1;
    repeat (3) tick();
    check("reset x", 32'(bx), 0);
    check("reset y", 32'(by), 0);
    check("reset moving", 32'(bmov), 0);
    check("reset upd", 32'(bupd), 0);
    check("reset bounce", 32'(bbnc), 0);
    rst = 1'b0;
    repeat (3) tick();
    check("held launch after reset", 32'(bmov), 0);

    launch_pulse();
    check("launch moving", 32'(bmov), 1);
    check("launch moving small", 32'(smov), 1);

    // First frame with per-edge latency checks.
    nf = 1'b1;
    tick();
    nf = 1'b0;
    check("upd at E", 32'(bupd), 0);
    tick();
    check("upd at E+1", 32'(bupd), 0);
    tick();
    check("upd at E+2", 32'(bupd), 0);
    check("x unchanged at E+2", 32'(bx), 0);
    tick();
    check("upd at E+3", 32'(bupd), 1);
    check("x at E+3", 32'(bx), 4);
    check("y at E+3", 32'(by), 4);
    check("bounce at E+3", 32'(bbnc), 0);
    check("small x f1", 32'(sx), 3);
    check("small y f1", 32'(sy), 3);
    tick();
    check("upd at E+4", 32'(bupd), 0);

    // Table-driven sweep through frame 316 (frames 317/318 come later).
    idx = 0;
    for (int f = 2; f <= 316; f++) begin
      do_frame();
      if (idx < 13 && tbl[idx].frame == f) begin
        check($sformatf("f%0d upd", f), 32'(cap_bupd), 1);
        check($sformatf("f%0d upd count", f), 32'(upd_cnt), 1);
        check($sformatf("f%0d x", f), 32'(cap_bx), 32'(tbl[idx].bx));
        check($sformatf("f%0d y", f), 32'(cap_by), 32'(tbl[idx].by));
        check($sformatf("f%0d bounce", f), 32'(cap_bbnc), 32'(tbl[idx].bb));
        if (tbl[idx].chk_s) begin
          check($sformatf("f%0d small upd", f), 32'(cap_supd), 1);
          check($sformatf("f%0d small x", f), 32'(cap_sx), 32'(tbl[idx].sx));
          check($sformatf("f%0d small y", f), 32'(cap_sy), 32'(tbl[idx].sy));
          check($sformatf("f%0d small bounce", f), 32'(cap_sbnc), 32'(tbl[idx].sb));
        end
        idx++;
      end
    end

    // Freeze across three frame pulses.
    freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      do_frame();
      check($sformatf("freeze %0d upd count", k), 32'(upd_cnt), 0);
      check($sformatf("freeze %0d x", k), 32'(bx), 1256);
      check($sformatf("freeze %0d y", k), 32'(by), 128);
    end
    freeze = 1'b0;
    do_frame();
    check("unfreeze upd", 32'(cap_bupd), 1);
    check("unfreeze x", 32'(cap_bx), 32'(tbl[13].bx));
    check("unfreeze y", 32'(cap_by), 32'(tbl[13].by));

    // nf held into UPD_X must not queue a second update.
    upd_cnt = 0;
    nf = 1'b1;
    tick();
    tick();
    nf = 1'b0;
    if (bupd) upd_cnt++;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bupd) upd_cnt++;
    end
    check("nf in UPD_X upd count", 32'(upd_cnt), 1);
    check("nf in UPD_X x", 32'(bx), 32'(tbl[14].bx));
    check("nf in UPD_X y", 32'(by), 32'(tbl[14].by));

    // Second launch edge in WAIT_NF stops, position held; frames then ignored.
    launch_pulse();
    check("stop moving", 32'(bmov), 0);
    check("stop x held", 32'(bx), 1248);
    check("stop y held", 32'(by), 120);
    do_frame();
    check("idle frame upd count", 32'(upd_cnt), 0);
    check("idle frame x", 32'(bx), 1248);

    // Relaunch restarts at +x,+y from the held position.
    launch_pulse();
    check("relaunch moving", 32'(bmov), 1);
    do_frame();
    check("relaunch x", 32'(cap_bx), 1252);
    check("relaunch y", 32'(cap_by), 124);
    check("relaunch bounce", 32'(cap_bbnc), 0);

    // Reset asserted while in UPD_Y.
    nf = 1'b1;
    tick();
    nf = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("rst in UPD_Y x", 32'(bx), 0);
    check("rst in UPD_Y y", 32'(by), 0);
    check("rst in UPD_Y moving", 32'(bmov), 0);
    check("rst in UPD_Y upd", 32'(bupd), 0);
    rst = 1'b0;
    upd_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bupd) upd_cnt++;
    end
    check("after rst upd count", 32'(upd_cnt), 0);
    check("after rst moving", 32'(bmov), 0);
    check("after rst x", 32'(bx), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_motion_ctrl.md
SPRITE_MOTION_CTRL -- requirements
Module: sprite_motion_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1280, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 720, active lines per frame.
REQ-003 SHALL have parameter SPRITE_W, default 20, sprite width in pixels.
REQ-004 SHALL have parameter SPRITE_H, default 24, sprite height in lines.
REQ-005 SHALL have parameter SPEED, default 4, pixels moved per axis per frame (1..15).
REQ-006 SHALL have port pixel_clk_in, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_in, input, 1, reset, synchronous and active-high.
REQ-008 SHALL have port nf_in, input, 1, one-cycle new-frame pulse from the video signal generator.
REQ-009 SHALL have port launch_in, input, 1, launch/stop request level, already synchronized.
REQ-010 SHALL have port freeze_in, input, 1, suppresses frame updates while high.
REQ-011 SHALL have port x_out, output, 11, sprite top-left x.
REQ-012 SHALL have port y_out, output, 10, sprite top-left y.
REQ-013 SHALL have port moving_out, output, 1, high in any state except IDLE.
REQ-014 SHALL have port upd_valid_out, output, 1, one-cycle pulse when x_out/y_out change.
REQ-015 SHALL have port bounce_out, output, 1, one-cycle pulse, coincident with upd_valid_out, when any axis reflected.

Function
REQ-016 FSM states: IDLE, WAIT_NF, UPD_X, UPD_Y, COMMIT.
REQ-017 launch_in rising edge (registered edge detect) in IDLE -> WAIT_NF; directions set to +x,+y.
REQ-018 launch_in rising edge in WAIT_NF -> IDLE; position held. Edges in UPD_X/UPD_Y/COMMIT ignored.
REQ-019 WAIT_NF with nf_in=1 and freeze_in=0 -> UPD_X; with freeze_in=1, stay in WAIT_NF, no update.
REQ-020 UPD_X -> UPD_Y -> COMMIT -> WAIT_NF, one cycle each, unconditional.
REQ-021 UPD_X computes next x in internal register; UPD_Y computes next y; COMMIT loads x_out/y_out.
REQ-022 Latency: nf_in sampled at edge E -> new x_out/y_out and upd_valid_out=1 visible after edge E+3, for one cycle.
REQ-023 nf_in high outside WAIT_NF is ignored (not queued).
REQ-024 X, dir +: if x+SPEED >= H_ACTIVE-SPRITE_W then x=H_ACTIVE-SPRITE_W, dir flips to -, bounce flagged; else x+=SPEED.
REQ-025 X, dir -: if x <= SPEED then x=0, dir flips to +, bounce flagged; else x-=SPEED.
REQ-026 Y identical to REQ-024/025 using V_ACTIVE, SPRITE_H.
REQ-027 Arithmetic in 12-bit unsigned; x_out never exceeds H_ACTIVE-SPRITE_W, y_out never exceeds V_ACTIVE-SPRITE_H.
REQ-028 Both axes reflecting in the same frame SHALL produce a single bounce_out pulse.

Reset
REQ-029 rst_in high at an edge -> state IDLE, x_out=0, y_out=0, dirs +x,+y, moving_out=0, upd_valid_out=0, bounce_out=0, edge detector cleared, regardless of current state.
REQ-030 launch_in held high through reset deassertion SHALL NOT count as a rising edge.

Configuration
REQ-031 Macro SPRITE_MOTION_LFSR_EN defined: launch sets initial x/y directions from bits [0]/[1] of a free-running 16-bit LFSR (seed 16'hACE1 on reset, taps 16,14,13,11; 1=+).
REQ-032 Macro undefined: no LFSR logic; launch directions fixed +x,+y.

Structure
REQ-033 Package sprite_motion_pkg SHALL hold the state enum typedef and the direction typedef.
REQ-034 Sub-module lfsr16 (step enable, reset seed, 16-bit state out) SHALL be instantiated only under SPRITE_MOTION_LFSR_EN.

Verification
REQ-035 Reset, launch pulse, nf_in at edge E -> x_out=4, y_out=4, upd_valid_out at E+3 only.
REQ-036 Preload path to x=1256 dir + (63 frames after... drive from 1252) next frame -> x_out=1260, dir -, bounce_out=1; next frame x_out=1256.
REQ-037 y at 2 dir - -> y_out=0, dir +, one bounce_out; corner case x and y reflect together -> single bounce_out.
REQ-038 freeze_in=1 across three nf_in pulses -> no upd_valid_out, outputs unchanged; release -> next nf_in updates.
REQ-039 rst_in asserted in UPD_Y -> next cycle IDLE, x_out=0, y_out=0, no upd_valid_out; nf_in in UPD_X ignored; second launch edge in WAIT_NF -> IDLE, position held.
